// File: rtl/adder_tree_pkg.sv
// ---------------------------------------------------------------------------
// adder_tree_pkg
// Shared definitions for the adder-tree reduction pipeline and its packer
// front end.
//   DATAWIDTH_DEF / NUM_INPUTS_DEF : default sample width and lane count
//   pack_state_t                   : packer FSM states (EMPTY, FILL)
//   lane_vec_t                     : packed lane vector at default sizing,
//                                    lane 0 in the least significant slot
// ---------------------------------------------------------------------------
package adder_tree_pkg;

    localparam int DATAWIDTH_DEF  = 4;
    localparam int NUM_INPUTS_DEF = 16;

    typedef enum logic {
        EMPTY = 1'b0,   // no lanes held
        FILL  = 1'b1    // 1..NUM_INPUTS-1 lanes held
    } pack_state_t;

    typedef logic [NUM_INPUTS_DEF-1:0][DATAWIDTH_DEF-1:0] lane_vec_t;

endpackage

// File: rtl/adder_tree_packer_if.sv
// ---------------------------------------------------------------------------
// adder_tree_packer_if
// Sample stream in, packed lane vector out.
//   s_valid/s_ready/s_data/s_last : narrow sample stream with group-close mark
//   i_flush                       : close the current group without a sample
//   o_valid/o_data/o_count        : one-cycle pulse, packed lanes, real lanes
// Modports: master = stream producer / vector consumer, slave = the packer.
// ---------------------------------------------------------------------------
interface adder_tree_packer_if
    import adder_tree_pkg::*;
#(
    parameter int DATAWIDTH  = DATAWIDTH_DEF,
    parameter int NUM_INPUTS = NUM_INPUTS_DEF
);
    localparam int CNT_W = $clog2(NUM_INPUTS + 1);

    logic                                  s_valid;
    logic                                  s_ready;
    logic [DATAWIDTH-1:0]                  s_data;
    logic                                  s_last;
    logic                                  i_flush;
    logic                                  o_valid;
    logic [NUM_INPUTS-1:0][DATAWIDTH-1:0]  o_data;
    logic [CNT_W-1:0]                      o_count;

    modport master (
        output s_valid, s_data, s_last, i_flush,
        input  s_ready, o_valid, o_data, o_count
    );

    modport slave (
        input  s_valid, s_data, s_last, i_flush,
        output s_ready, o_valid, o_data, o_count
    );

endinterface

// File: rtl/packer_lane_buffer.sv
// ---------------------------------------------------------------------------
// packer_lane_buffer
// NUM_INPUTS x DATAWIDTH register array holding the group being assembled.
//   clk, rst   : clock, asynchronous active-low reset
//   wr_en      : write wr_data into lane wr_idx
//   wr_idx     : lane index of the incoming sample
//   wr_data    : incoming sample
//   clr        : synchronous clear of every lane (wins over wr_en)
//   fill_cnt   : lanes that are real, including the incoming sample
//   merged     : stored lanes with the incoming sample merged in and every
//                lane at or above fill_cnt forced to zero
// ---------------------------------------------------------------------------
module packer_lane_buffer #(
    parameter int DATAWIDTH  = 4,
    parameter int NUM_INPUTS = 16,
    parameter int CNT_W      = $clog2(NUM_INPUTS + 1)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [CNT_W-1:0]                     wr_idx,
    input  logic [DATAWIDTH-1:0]                 wr_data,
    input  logic                                 clr,
    input  logic [CNT_W-1:0]                     fill_cnt,
    output logic [NUM_INPUTS-1:0][DATAWIDTH-1:0] merged
);

    logic [DATAWIDTH-1:0] lane_q [NUM_INPUTS];
    logic [DATAWIDTH-1:0] lane_d [NUM_INPUTS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_INPUTS; gi++) begin : g_lane
            localparam logic [CNT_W-1:0] LANE_IDX = CNT_W'(gi);

            always_comb begin
                lane_d[gi] = lane_q[gi];
                if (clr) begin
                    lane_d[gi] = '0;
                end else if (wr_en && (wr_idx == LANE_IDX)) begin
                    lane_d[gi] = wr_data;
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    lane_q[gi] <= '0;
                end else begin
                    lane_q[gi] <= lane_d[gi];
                end
            end

            // Padding is enforced here from the count rather than relying on
            // the buffer having been cleared, so stale data can never leak.
            always_comb begin
                merged[gi] = '0;
                if (LANE_IDX < fill_cnt) begin
                    if (wr_en && (wr_idx == LANE_IDX)) begin
                        merged[gi] = wr_data;
                    end else begin
                        merged[gi] = lane_q[gi];
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/adder_tree_packer.sv
// ---------------------------------------------------------------------------
// adder_tree_packer
// Deserializer in front of the adder tree: packs NUM_INPUTS consecutive
// samples into one lane vector, issued with a one-cycle o_valid pulse.
// Groups may close early on s_last or i_flush; unused lanes are zero.
//   clk  : rising-edge clock
//   rst  : asynchronous active-low reset
//   bus  : adder_tree_packer_if.slave (sample stream in, lane vector out)
// The output register is separate from the fill buffer, so s_ready stays
// high once out of reset and the next sample can land in lane 0 on the
// cycle right after an emit.
// ---------------------------------------------------------------------------
module adder_tree_packer
    import adder_tree_pkg::*;
#(
    parameter int DATAWIDTH  = DATAWIDTH_DEF,
    parameter int NUM_INPUTS = NUM_INPUTS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    adder_tree_packer_if.slave   bus
);

    localparam int CNT_W = $clog2(NUM_INPUTS + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(NUM_INPUTS);

    pack_state_t                          state_q,   state_d;
    logic [CNT_W-1:0]                     cnt_q,     cnt_d;
    logic                                 s_ready_q;
    logic                                 o_valid_q, o_valid_d;
    logic [NUM_INPUTS-1:0][DATAWIDTH-1:0] o_data_q,  o_data_d;
    logic [CNT_W-1:0]                     o_count_q, o_count_d;

    logic                                 accept;
    logic                                 close;
    logic [CNT_W-1:0]                     fill_cnt;
    logic [NUM_INPUTS-1:0][DATAWIDTH-1:0] merged;

    always_comb begin
        accept   = bus.s_valid && s_ready_q;
        fill_cnt = cnt_q + CNT_W'(accept);
        // A flush with no sample only matters when something is held;
        // a flush alongside a sample behaves like s_last.
        close    = (accept && ((fill_cnt == FULL_CNT) || bus.s_last || bus.i_flush))
                || (s_ready_q && bus.i_flush && (state_q == FILL));
    end

    packer_lane_buffer #(
        .DATAWIDTH  (DATAWIDTH),
        .NUM_INPUTS (NUM_INPUTS),
        .CNT_W      (CNT_W)
    ) u_lane_buffer (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (accept),
        .wr_idx   (cnt_q),
        .wr_data  (bus.s_data),
        .clr      (close),
        .fill_cnt (fill_cnt),
        .merged   (merged)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        o_valid_d = 1'b0;
        o_data_d  = o_data_q;
        o_count_d = o_count_q;
        if (close) begin
            state_d   = EMPTY;
            cnt_d     = '0;
            o_valid_d = 1'b1;
            o_data_d  = merged;
            o_count_d = fill_cnt;
        end else if (accept) begin
            state_d   = FILL;
            cnt_d     = fill_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= EMPTY;
            cnt_q     <= '0;
            s_ready_q <= 1'b0;
            o_valid_q <= 1'b0;
            o_data_q  <= '0;
            o_count_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            s_ready_q <= 1'b1;
            o_valid_q <= o_valid_d;
            o_data_q  <= o_data_d;
            o_count_q <= o_count_d;
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.o_valid = o_valid_q;
    assign bus.o_data  = o_data_q;
    assign bus.o_count = o_count_q;

endmodule

// File: tb/tb_adder_tree_packer.sv
// ---------------------------------------------------------------------------
// tb_adder_tree_packer
// Stimulus keeps the current group as a queue of samples; whenever a group
// closes, the expected lane vector, count and arrival cycle are pushed to a
// scoreboard. A monitor on the falling edge compares every DUT output.
// ---------------------------------------------------------------------------
module tb_adder_tree_packer;
    import adder_tree_pkg::*;

    localparam int DW    = 4;
    localparam int N     = 4;
    localparam int CNT_W = $clog2(N + 1);

    typedef logic [N-1:0][DW-1:0] vec_t;
    typedef struct {
        vec_t data;
        int   cnt;
        int   cyc;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;
    int   tests;
    int   fails;
    logic ready_m;
    logic [DW-1:0] grp[$];
    exp_t sb[$];
    vec_t last_data;
    int   last_cnt;

    adder_tree_packer_if #(.DATAWIDTH(DW), .NUM_INPUTS(N)) bus ();

    adder_tree_packer #(.DATAWIDTH(DW), .NUM_INPUTS(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, req);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            check("reset s_ready", longint'(bus.s_ready), 0);
            check("reset o_valid", longint'(bus.o_valid), 0);
            check("reset o_data",  longint'(bus.o_data), 0);
            check("reset o_count", longint'(bus.o_count), 0);
            last_data = '0;
            last_cnt  = 0;
        end else begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                check("missing pulse", longint'(cyc), longint'(sb[0].cyc));
                void'(sb.pop_front());
            end
            check("s_ready", longint'(bus.s_ready), longint'(ready_m));
            if (bus.o_valid) begin
                if (sb.size() == 0 || sb[0].cyc != cyc) begin
                    check("unexpected pulse", 1, 0);
                end else begin
                    check("o_data",  longint'(bus.o_data),  longint'(sb[0].data));
                    check("o_count", longint'(bus.o_count), longint'(sb[0].cnt));
                    $display("[TB] cycle %0d emit data=%h count=%0d", cyc, bus.o_data, bus.o_count);
                    last_data = sb[0].data;
                    last_cnt  = sb[0].cnt;
                    void'(sb.pop_front());
                end
            end else begin
                check("hold o_data",  longint'(bus.o_data),  longint'(last_data));
                check("hold o_count", longint'(bus.o_count), longint'(last_cnt));
            end
        end
    end

    task automatic emit_group();
        exp_t e;
        e.data = '0;
        for (int i = 0; i < grp.size(); i++) e.data[i] = grp[i];
        e.cnt = grp.size();
        e.cyc = cyc + 1;
        sb.push_back(e);
        grp.delete();
    endtask

    // Drive one cycle of inputs, update the reference model, advance a clock.
    task automatic step(input logic v, input logic [DW-1:0] d, input logic l, input logic f);
        bus.s_valid = v;
        bus.s_data  = d;
        bus.s_last  = l;
        bus.i_flush = f;
        if (v && ready_m) begin
            grp.push_back(d);
            if (grp.size() == N || l || f) emit_group();
        end else if (f && ready_m && grp.size() > 0) begin
            emit_group();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        grp.delete();
        sb.delete();
        ready_m = 1'b0;
        $display("[TB] cycle %0d reset asserted for %0d cycles", cyc, n);
        for (int i = 0; i < n; i++) step(1'b1, 4'(i + 5), 1'b0, 1'b0);
        rst = 1'b1;
        step(1'b1, 4'hE, 1'b1, 1'b1);   // ignored: s_ready is still low
        ready_m = 1'b1;
        check("s_ready after release", longint'(bus.s_ready), 1);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        ready_m = 1'b0;
        last_data = '0;
        last_cnt = 0;
        rst = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.i_flush = 1'b0;
        #2;
        do_reset(3);

        // Full group, then continuous stream of two groups
        for (int i = 1; i <= 4; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
        // Partial group closed by s_last, next sample lands in lane 0
        step(1'b1, 4'd9, 1'b0, 1'b0);
        step(1'b1, 4'd10, 1'b1, 1'b0);
        step(1'b1, 4'd11, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        // Flush in EMPTY does nothing; flush alone closes a one-sample group
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        step(1'b1, 4'd7, 1'b0, 1'b0);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        // Flush with an accepted sample from EMPTY, s_last on 4th sample
        step(1'b1, 4'd3, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) step(1'b1, 4'(i + 11), (i == 4), 1'b0);
        step(1'b1, 4'd15, 1'b1, 1'b0);
        // Reset mid-group discards the partial group
        for (int i = 1; i <= 3; i++) step(1'b1, 4'(i), 1'b0, 1'b0);
        do_reset(1);
        for (int i = 1; i <= 4; i++) step(1'b1, 4'(i + 4), 1'b0, 1'b0);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(int'($urandom_range(1, 2)));
            end else begin
                step(($urandom_range(0, 3) != 0), 4'($urandom),
                     ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) == 0));
            end
        end

        for (int i = 0; i < 4; i++) step(1'b0, 4'h0, 1'b0, 1'b0);
        check("scoreboard drained", longint'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
